host_interface_burst: RTL

- Parametrised successor to the FX2 GPIF host bridge.
- Decodes the registered GPIF `state`/`ctl` stream from the FX2 and drives the device-interface (`di_*`) bus to terminals.
- Adds counted burst writes with address auto-increment, a prefetch read FIFO that hides `di_read_rdy` latency, and parametrised widths (multi-word transfer count).

---
 rtl/host_interface_burst.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/host_interface_burst.sv
// FX2 GPIF host bridge: decodes the registered state/ctl stream into device-interface
// accesses, with counted write bursts, auto-increment addressing and a prefetching read FIFO.
module host_interface_burst #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TC_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_INC   = 1
) (
    input  logic                  ifclk,
    input  logic                  resetb,
    input  logic [2:0]            ctl,
    input  logic [3:0]            state,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_oe,
    output logic [1:0]            rdy,
    output logic [ADDR_WIDTH-1:0] di_term_addr,
    output logic [ADDR_WIDTH-1:0] di_reg_addr,
    output logic [DATA_WIDTH-1:0] di_reg_datai,
    input  logic [DATA_WIDTH-1:0] di_reg_datao,
    output logic                  di_read,
    input  logic                  di_read_rdy,
    output logic                  di_write,
    input  logic                  di_write_rdy
);
    localparam logic [3:0] ST_SETEP   = 4'd1;
    localparam logic [3:0] ST_SETADDR = 4'd2;
    localparam logic [3:0] ST_RDDATA  = 4'd4;
    localparam logic [3:0] ST_RDTC_LO = 4'd7;
    localparam logic [3:0] ST_WRDATA  = 4'd8;
    localparam logic [3:0] ST_RDTC_HI = 4'd9;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [3:0]            state_q;
    logic [2:1]            ctl_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] term_addr_q, term_addr_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0] reg_datai_q, reg_datai_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [1:0]            rdy_q, rdy_d;
    logic                  oe_q, oe_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [TC_WIDTH-1:0]   tc_q, tc_d;
    logic [TC_WIDTH-1:0]   tc_reset_q, tc_reset_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0] tc_ext;
    logic push, pop, flush, strobe, active;
    logic ctl_unused;

    assign ctl_unused = ctl[0];
    assign strobe = ctl_q[1];
    assign active = ctl_q[2];

    always_comb begin
        term_addr_d = term_addr_q;
        reg_addr_d  = reg_addr_q;
        reg_datai_d = reg_datai_q;
        tc_d        = tc_q;
        tc_reset_d  = tc_reset_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        rdy_d       = 2'b00;
        oe_d        = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b1;
        tc_ext      = '0;
        tc_ext[TC_WIDTH-1:0] = tc_reset_q;

        // The address steps at the end of each access pulse; an explicit SETADDR load wins.
        if (ADDR_INC != 0 && (read_q || write_q))
            reg_addr_d = reg_addr_q + ADDR_WIDTH'(1);

        case (state_q)
            ST_SETEP: begin
                rdy_d = 2'b01;
                if (strobe) term_addr_d = data_q[ADDR_WIDTH-1:0];
            end
            ST_SETADDR: begin
                rdy_d = 2'b01;
                if (strobe) reg_addr_d = data_q[ADDR_WIDTH-1:0];
            end
            ST_RDTC_LO: begin
                rdy_d = 2'b01;
                if (strobe) begin
                    tc_ext[DATA_WIDTH-1:0] = data_q;
                    tc_reset_d = tc_ext[TC_WIDTH-1:0];
                    tc_d       = tc_ext[TC_WIDTH-1:0];
                end
            end
            ST_RDTC_HI: begin
                rdy_d = 2'b01;
                if (strobe && TC_WIDTH > DATA_WIDTH) begin
                    tc_ext[2*DATA_WIDTH-1:DATA_WIDTH] = data_q;
                    tc_reset_d = tc_ext[TC_WIDTH-1:0];
                    tc_d       = tc_ext[TC_WIDTH-1:0];
                end
            end
            ST_WRDATA: begin
                if (!active) begin
                    tc_d = tc_reset_q;
                end else if (strobe && tc_q != '0) begin
                    write_d     = 1'b1;
                    reg_datai_d = data_q;
                    tc_d        = tc_q - TC_WIDTH'(1);
                end
                rdy_d = {tc_d == '0, di_write_rdy && tc_d != '0};
            end
            ST_RDDATA: begin
                oe_d = 1'b1;
                if (!active) begin
                    tc_d = tc_reset_q;
                end else begin
                    flush = 1'b0;
                    push  = read_q;
                    pop   = strobe && count_q != '0;
                    // A read still in flight already owns a slot, so it counts against free space.
                    if (di_read_rdy && tc_q != '0 && (count_q + CW'(read_q)) < DEPTH_C) begin
                        read_d = 1'b1;
                        tc_d   = tc_q - TC_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
        end else begin
            wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_d  = count_q + CW'(push) - CW'(pop);
            dout_d   = (push && wr_ptr_q == rd_ptr_d) ? di_reg_datao : mem[rd_ptr_d];
        end

        if (state_q == ST_RDDATA)
            rdy_d = {tc_d == '0 && count_d == '0 && !read_d, count_d != '0};
    end

    always_ff @(posedge ifclk) begin
        if (push) mem[wr_ptr_q] <= di_reg_datao;
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= '0;
            ctl_q       <= '0;
            data_q      <= '0;
            term_addr_q <= '0;
            reg_addr_q  <= '0;
            reg_datai_q <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rdy_q       <= '0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
            tc_q        <= '0;
            tc_reset_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state;
            ctl_q       <= ctl[2:1];
            data_q      <= data_i;
            term_addr_q <= term_addr_d;
            reg_addr_q  <= reg_addr_d;
            reg_datai_q <= reg_datai_d;
            read_q      <= read_d;
            write_q     <= write_d;
            rdy_q       <= rdy_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            tc_q        <= tc_d;
            tc_reset_q  <= tc_reset_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign data_o       = dout_q;
    assign data_oe      = oe_q;
    assign rdy          = rdy_q;
    assign di_term_addr = term_addr_q;
    assign di_reg_addr  = reg_addr_q;
    assign di_reg_datai = reg_datai_q;
    assign di_read      = read_q;
    assign di_write     = write_q;
endmodule
